// File: rtl/cla_seq_adder_pkg.sv
// Shared constants for the nibble-serial CLA adder: FSM encoding, slice width and
// the signed-overflow rule.
package cla_seq_adder_pkg;

   localparam int unsigned NIBW = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Overflow when both addends share a sign that the result does not.
   function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                       input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/cla_seq_adder_cla4.sv
// Purely combinational 4-bit carry-lookahead adder slice.
module CLA_4_bit
   import cla_seq_adder_pkg::*;
(
   input  logic [NIBW-1:0] a,
   input  logic [NIBW-1:0] b,
   input  logic            cin,
   output logic [NIBW-1:0] s,
   output logic            cout
);

   logic [NIBW-1:0] g;
   logic [NIBW-1:0] p;
   logic [NIBW:0]   c;

   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
      s    = p ^ c[NIBW-1:0];
      cout = c[NIBW];
   end

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle add/subtract: one nibble per cycle through a single CLA slice, with the
// slice carry registered and fed into the next nibble.
module cla_seq_adder
   import cla_seq_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NIB = WIDTH / NIBW;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIB - 1);

   logic [1:0]       state;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             carry;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;
   logic             ovf_r;

   logic [NIBW-1:0]  nib_a;
   logic [NIBW-1:0]  nib_b;
   logic [NIBW-1:0]  nib_s;
   logic             nib_cout;
   logic             take;

   assign nib_a = a_r[NIBW*idx +: NIBW];
   assign nib_b = b_r[NIBW*idx +: NIBW];

   CLA_4_bit u_slice (
      .a    (nib_a),
      .b    (nib_b),
      .cin  (carry),
      .s    (nib_s),
      .cout (nib_cout)
   );

   // Accumulator with the current nibble merged in; becomes the full result on the last step.
   always_comb begin
      acc_next = acc;
      acc_next[NIBW*idx +: NIBW] = nib_s;
   end

   assign take = start && ((state == ST_IDLE) || (state == ST_DONE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         idx    <= '0;
         a_r    <= '0;
         b_r    <= '0;
         carry  <= 1'b0;
         acc    <= '0;
         sum_r  <= '0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               acc   <= acc_next;
               carry <= nib_cout;
               idx   <= idx + 1'b1;
               if (idx == LAST) begin
                  state  <= ST_DONE;
                  idx    <= '0;
                  sum_r  <= acc_next;
                  cout_r <= nib_cout;
                  ovf_r  <= signed_ovf(a_r[WIDTH-1], b_r[WIDTH-1], acc_next[WIDTH-1]);
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
         if (take) begin
            state <= ST_RUN;
            idx   <= '0;
            a_r   <= a;
            b_r   <= b ^ {WIDTH{sub}};
            carry <= sub | cin;
            acc   <= '0;
         end
      end
   end

   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);
   assign sum  = sum_r;
   assign cout = cout_r;
   assign ovf  = ovf_r;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder: vector table, back-to-back starts, mid-op reset, WIDTH=8.
module tb_cla_seq_adder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        cin = 1'b0;
   logic        sub = 1'b0;
   logic        busy, done, cout, ovf;
   logic [15:0] sum;

   logic        start8 = 1'b0;
   logic [7:0]  a8 = '0;
   logic [7:0]  b8 = '0;
   logic        busy8, done8, cout8, ovf8;
   logic [7:0]  sum8;

   always #5 clk = ~clk;

   cla_seq_adder #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
   );

   cla_seq_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(1'b0), .sub(1'b0),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] s;
      logic        co;
      logic        ov;
   } vec_t;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: {cout, ovf, sum} from a plain 17-bit add.
   function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                         input logic c, input logic s);
      logic [15:0] ye;
      logic [16:0] r;
      logic        o;
      ye = s ? ~y : y;
      r  = {1'b0, x} + {1'b0, ye} + {16'd0, (s | c)};
      o  = (x[15] == ye[15]) && (r[15] != x[15]);
      return {r[16], o, r[15:0]};
   endfunction

   // One operation; perturbs inputs and pulses start while busy, which must be ignored.
   task automatic do_op(input vec_t v, input string tag);
      int cyc = 0;
      int busy_n = 0;
      int done_at = 0;
      @(negedge clk);
      start = 1'b1; a = v.a; b = v.b; cin = v.cin; sub = v.sub;
      while (cyc < 12 && done_at == 0) begin
         @(negedge clk);
         cyc++;
         if (busy) busy_n++;
         if (done) begin
            done_at = cyc;
            check({tag, "_sum"}, 32'(sum), 32'(v.s));
            check({tag, "_cout"}, 32'(cout), 32'(v.co));
            check({tag, "_ovf"}, 32'(ovf), 32'(v.ov));
            check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
         end
         start = (cyc == 2);
         a = ~v.a; b = v.b ^ 16'h5a5a; cin = ~v.cin; sub = ~v.sub;
      end
      check({tag, "_latency"}, 32'(done_at), 32'd5);
      check({tag, "_busy_cycles"}, 32'(busy_n), 32'd4);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_sum_held"}, 32'(sum), 32'(v.s));
   endtask

   vec_t tbl[8];

   initial begin
      logic [15:0] oa[16];
      logic [15:0] ob[16];
      logic        oc[16];
      logic [17:0] e;
      int          d8;

      tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      tbl[2] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
      tbl[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      tbl[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      tbl[6] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
      tbl[7] = '{16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};

      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) do_op(tbl[i], $sformatf("vec%0d", i));

      // Back-to-back: start held, operands change every cycle; captures at offsets 0, 5, 10.
      for (int m = 0; m < 16; m++) begin
         oa[m] = 16'(m * 4919 + 100);
         ob[m] = 16'(m * 7001 + 3);
         oc[m] = m[0];
      end
      @(negedge clk);
      for (int m = 0; m <= 15; m++) begin
         if (m > 0) begin
            check($sformatf("b2b_done_%0d", m), 32'(done),
                  32'((m == 5) || (m == 10) || (m == 15)));
            if (m == 5 || m == 10 || m == 15) begin
               e = model(oa[m-5], ob[m-5], oc[m-5], 1'b0);
               check($sformatf("b2b_sum_%0d", m), 32'(sum), 32'(e[15:0]));
               check($sformatf("b2b_cout_%0d", m), 32'(cout), 32'(e[17]));
               check($sformatf("b2b_ovf_%0d", m), 32'(ovf), 32'(e[16]));
            end
         end
         if (m < 15) begin
            start = 1'b1; a = oa[m]; b = ob[m]; cin = oc[m]; sub = 1'b0;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end

      // Reset two cycles into RUN.
      start = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      start = 1'b0;
      check("midrst_busy_before", 32'(busy), 32'd1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_sum", 32'(sum), 32'd0);
      check("midrst_cout", 32'(cout), 32'd0);
      check("midrst_ovf", 32'(ovf), 32'd0);
      repeat (3) begin
         @(negedge clk);
         check("midrst_no_done", 32'(done), 32'd0);
      end
      rst_n = 1'b1;
      do_op('{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0}, "postrst");

      // WIDTH=8 instance.
      @(negedge clk);
      start8 = 1'b1; a8 = 8'hF0; b8 = 8'h10;
      d8 = 0;
      for (int c = 1; c <= 10 && d8 == 0; c++) begin
         @(negedge clk);
         start8 = 1'b0;
         if (done8) begin
            d8 = c;
            check("w8_sum", 32'(sum8), 32'h00);
            check("w8_cout", 32'(cout8), 32'd1);
            check("w8_ovf", 32'(ovf8), 32'd0);
         end
      end
      check("w8_latency", 32'(d8), 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
